q_lowqli_out: RTL and testbench
===============================

# q_lowqli_out

Page output queue: a single-stream elastic FIFO placed on every stream leaving a page. It carries one token (16-bit data plus end-of-stream flag, packed as `{d, e}`) per valid/back-pressure transfer toward the network. Back-pressure reaches the page early enough that tokens already in flight from the page pipeline still have room. Pages with N output streams instantiate N copies.

## Interface
- `WIDTH`, 17, token width; bit 0 is the EOS flag, bits `WIDTH-1:1` are data.
- `DEPTH`, 4, entries including the output register; power of two, ≥2.
- `LOG_DEPTH`, 2, log2(`DEPTH`).
- `SLACK`, 1, tokens the producer may still send after `qin_b` rises; 0 ≤ `SLACK` < `DEPTH`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `qin_d`  in  `WIDTH`  token from page.
- `qin_v`  in  1  `qin_d` valid.
- `qin_b`  out  1  back-pressure to page.
- `qout_d`  out  `WIDTH`  head token.
- `qout_v`  out  1  `qout_d` valid.
- `qout_b`  in  1  back-pressure from downstream.
- `ovf`  out  1  sticky overflow; present only with `Q_LOWQLI_OUT_OVF_CHECK_EN`.

## Operation
- `count` holds the number of stored tokens, 0..`DEPTH`, and is `LOG_DEPTH+1` bits wide. It includes the output register.
- Storage is a ring of `DEPTH-1` entries with wrapping read and write pointers, plus an output register that drives `qout_d`/`qout_v`.
- **Dequeue** happens when `qout_v && !qout_b`.
- **Enqueue** happens when `qin_v && (count < DEPTH || dequeue)`.
- `qin_b` is advisory only. A token is accepted while `qin_b` is high if there is space. This is the slack window.
- **Drop:** a token is dropped when `qin_v && count == DEPTH && !dequeue`. Queue state is unchanged.
- `qin_b = (count >= DEPTH - SLACK)`. It is combinational from the registered `count`.
- Output register fill priority:
  - Refill from the ring head if the ring is non-empty.
  - Otherwise, load directly from `qin_d` (bypass) if enqueuing.
  - Otherwise, clear `qout_v`.
- When `qout_v` is low, an enqueue loads the output register directly.
- Tokens leave strictly in arrival order. The EOS bit is passed through untouched; the queue does not interpret it.
- Pointers wrap modulo `DEPTH-1`. The ring is empty when `count` ≤ 1 with `qout_v` set, or when `count` is 0.
- Simultaneous enqueue and dequeue leaves `count` unchanged, including at `count == DEPTH` and at `count == 1` (bypass).

## Timing
- Reset values: `qout_v`=0, `qout_d`=0, `count`=0, pointers=0, `ovf`=0, and `qin_b` = (`SLACK` ≥ `DEPTH`), which is 0 for legal parameters.
- Latency: a token enqueued at edge t presents on `qout_v`/`qout_d` after edge t (visible in cycle t+1) when the queue was empty. This is a minimum of 1 cycle, with no combinational `qin`→`qout` path.
- Throughput is 1 token per cycle sustained when `qout_b` is low.
- `qin_b` rises in the cycle after the enqueue that takes `count` to `DEPTH-SLACK`. It falls in the cycle after the dequeue that takes `count` below that threshold.
- `qout_d` is stable while `qout_v && qout_b`.
- Reset asserted mid-stream discards all tokens immediately (asynchronous). Operation resumes on the first edge after release.

## Configuration
- `Q_LOWQLI_OUT_OVF_CHECK_EN` defined:
  - Port `ovf` exists.
  - `ovf` sets on the first dropped token and stays set until reset.
  - A simulation-only `$display` reports the drop time.
- `Q_LOWQLI_OUT_OVF_CHECK_EN` undefined:
  - No `ovf` port.
  - Drops are silent.
  - Behaviour is otherwise identical.

## Test plan
- **Reset:** assert `reset` mid-cycle with 3 tokens held -> `qout_v`=0, `qin_b`=0, `ovf`=0 at once. The first token after release is 0x0002 (EOS=0).
- **Latency and streaming:** with `qout_b`=0, send 0x0010..0x001F one per cycle -> `qout` shows the same sequence, each 1 cycle later, with no gaps.
- **Back-pressure threshold** (defaults): hold `qout_b`=1 and send 4 tokens -> `qin_b` rises after the 3rd is accepted and the 4th is still accepted (count=4). A 5th token with `qout_b`=1 is dropped and `ovf`=1.
- **Full with simultaneous events:** at count=4, drive `qin_v`=1 with `qout_b`=0 -> both transfers occur, count stays 4, `ovf` stays 0, order is preserved.
- **Wrap-around and EOS:** push 11 tokens with random `qout_b` stalls, the last being 0x0001 (EOS) -> output order matches input, the EOS token arrives last intact, and `qout_d` holds steady during every stall.

Source files
------------

// File: rtl/q_lowqli_out.sv
// q_lowqli_out: single-stream elastic output queue for a page stream.
// Ring of DEPTH-1 entries plus an output register that drives qout_*.
// qin_b is advisory: it asserts SLACK entries early, and tokens are still
// accepted while there is room. A token arriving at a full queue that is
// not draining is dropped.
// Optional feature macro: Q_LOWQLI_OUT_OVF_CHECK_EN adds a sticky `ovf`
// port and a simulation-only drop report.
module q_lowqli_out #(
  parameter int WIDTH     = 17,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  parameter int SLACK     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] qin_d,
  input  logic             qin_v,
  output logic             qin_b,
  output logic [WIDTH-1:0] qout_d,
  output logic             qout_v,
  input  logic             qout_b
`ifdef Q_LOWQLI_OUT_OVF_CHECK_EN
  ,
  output logic             ovf
`endif
);

  localparam int RING   = DEPTH - 1;
  localparam int LAST_I = DEPTH - 2;
  localparam int THR_I  = DEPTH - SLACK;
  localparam logic [LOG_DEPTH:0]   FULL = DEPTH[LOG_DEPTH:0];
  localparam logic [LOG_DEPTH:0]   THR  = THR_I[LOG_DEPTH:0];
  localparam logic [LOG_DEPTH:0]   ONE  = {{LOG_DEPTH{1'b0}}, 1'b1};
  localparam logic [LOG_DEPTH-1:0] LAST = LAST_I[LOG_DEPTH-1:0];

  logic [WIDTH-1:0]     ring_q [RING];
  logic [LOG_DEPTH-1:0] rd_ptr, wr_ptr;
  logic [LOG_DEPTH:0]   count;

  logic deq, enq, drop, ring_empty, load_out, ring_rd, ring_wr, bypass;

  // Transfer decisions, all from registered state plus this cycle's handshakes.
  // The output register is empty only when the whole queue is empty, so
  // ring occupancy is count minus the output register.
  always_comb begin
    deq        = qout_v && !qout_b;
    enq        = qin_v && ((count < FULL) || deq);
    drop       = qin_v && (count == FULL) && !deq;
    ring_empty = (count == '0) || (qout_v && (count == ONE));
    load_out   = !qout_v || deq;
    ring_rd    = load_out && !ring_empty;
    bypass     = load_out && ring_empty && enq;
    ring_wr    = enq && !bypass;
    qin_b      = (count >= THR);
  end

  // Output register, pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      qout_v <= 1'b0;
      qout_d <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (load_out) begin
        if (ring_rd) begin
          qout_v <= 1'b1;
          qout_d <= ring_q[rd_ptr];
        end else if (bypass) begin
          qout_v <= 1'b1;
          qout_d <= qin_d;
        end else begin
          qout_v <= 1'b0;
        end
      end
      if (ring_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (ring_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (enq && !deq)      count <= count + ONE;
      else if (deq && !enq) count <= count - ONE;
    end
  end

  // Ring storage. When full and draining, the head slot is read (old value)
  // and rewritten in the same cycle, which the nonblocking write allows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RING; i++) ring_q[i] <= '0;
    end else if (ring_wr) begin
      ring_q[wr_ptr] <= qin_d;
    end
  end

`ifdef Q_LOWQLI_OUT_OVF_CHECK_EN
  // Sticky overflow: set on the first dropped token, held until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

`ifndef SYNTHESIS
  // Simulation-only drop report.
  always @(posedge clock) begin
    if (!reset && drop) $display("q_lowqli_out: token dropped at %0t", $time);
  end
`endif
`endif

endmodule

// File: tb/tb_q_lowqli_out.sv
// Randomized self-checking bench for q_lowqli_out against a token-queue model.
module tb_q_lowqli_out;
  localparam int WIDTH = 17, DEPTH = 4, LOG_DEPTH = 2, SLACK = 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] qin_d = '0;
  logic             qin_v = 1'b0;
  logic             qin_b;
  logic [WIDTH-1:0] qout_d;
  logic             qout_v;
  logic             qout_b = 1'b0;
`ifdef Q_LOWQLI_OUT_OVF_CHECK_EN
  logic             ovf;
`endif

  q_lowqli_out #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH), .SLACK(SLACK)) dut (
    .clock (clock),
    .reset (reset),
    .qin_d (qin_d),
    .qin_v (qin_v),
    .qin_b (qin_b),
    .qout_d(qout_d),
    .qout_v(qout_v),
    .qout_b(qout_b)
`ifdef Q_LOWQLI_OUT_OVF_CHECK_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  logic [WIDTH-1:0] mq[$];      // tokens held, head first
  logic             exp_ovf = 1'b0;
  logic             stalled = 1'b0;
  logic [WIDTH-1:0] held_d  = '0;
  logic [WIDTH-1:0] last_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outputs depend on registered state only; compare against the model.
  task automatic check_state();
    chk("qout_v", qout_v, mq.size() > 0);
    if (mq.size() > 0) chk("qout_d", qout_d, mq[0]);
    chk("qin_b", qin_b, mq.size() >= DEPTH - SLACK);
    if (stalled) chk("hold", qout_d, held_d);
`ifdef Q_LOWQLI_OUT_OVF_CHECK_EN
    chk("ovf", ovf, exp_ovf);
`endif
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic b);
    logic edeq, eenq;
    @(negedge clock);
    qin_v = v; qin_d = d; qout_b = b;
    check_state();
    edeq = (mq.size() > 0) && !b;
    eenq = v && ((mq.size() < DEPTH) || edeq);
    if (v && !eenq) exp_ovf = 1'b1;
    stalled = (mq.size() > 0) && b;
    if (stalled) held_d = mq[0];
    @(posedge clock);
    if (edeq) last_out = mq.pop_front();
    if (eenq) mq.push_back(d);
  endtask

  task automatic drain(input logic rnd);
    int guard = 0;
    while (mq.size() > 0 && guard < 200) begin
      step(1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      guard++;
    end
    chk("drain_bound", guard < 200, 1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_qout_v", qout_v, 0);
    chk("rst_qout_d", qout_d, 0);
    chk("rst_qin_b", qin_b, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Streaming 0x10..0x1F, no back-pressure
    for (int i = 16; i < 32; i++) step(1'b1, WIDTH'(i), 1'b0);
    drain(1'b0);

    // Threshold: four tokens under back-pressure, qin_b after the third
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(32'h40 + 2 * i), 1'b1);
    chk("full_model", mq.size(), 4);
    // Full with simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(32'h50 + 2 * i), 1'b0);
    chk("full_keep", mq.size(), 4);
    // Fifth token at full and stalled is dropped
    step(1'b1, WIDTH'(32'h66), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("drop_model", mq.size(), 4);
    drain(1'b0);

    // Wrap-around with random stalls, EOS token last
    begin
      int sent = 0, guard = 0;
      while (sent < 11 && guard < 300) begin
        logic [WIDTH-1:0] tok;
        logic v;
        tok = (sent == 10) ? WIDTH'(1) : WIDTH'({$urandom_range(1, 65535), 1'b0});
        v = (mq.size() < DEPTH - SLACK) && ($urandom_range(0, 3) != 0);
        step(v, tok, 1'($urandom_range(0, 1)));
        if (v) sent++;
        guard++;
      end
      chk("wrap_bound", guard < 300, 1);
      drain(1'b1);
      chk("eos_last", last_out, 1);
    end

    // Random traffic, drops included
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 2) == 0));
    drain(1'b1);

    // Mid-cycle reset with three tokens held
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(32'h80 + 2 * i), 1'b1);
    @(negedge clock);
    qin_v = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_qout_v", qout_v, 0);
    chk("mid_rst_qin_b", qin_b, 0);
`ifdef Q_LOWQLI_OUT_OVF_CHECK_EN
    chk("mid_rst_ovf", ovf, 0);
`endif
    mq.delete();
    exp_ovf = 1'b0;
    stalled = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, WIDTH'(2), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("post_rst_tok", last_out, 2);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: no finish by %0t", $time);
    $fatal(1);
  end
endmodule
